// File: rtl/rr_mux41_arbiter_if.sv
// Handshake/bus bundle between four producer lanes, the arbiter and a single consumer.
interface rr_mux41_arbiter_if #(
  parameter int W = 1
);
  logic [3:0]     req;
  logic [4*W-1:0] d;
  logic           rdy;
  logic [3:0]     gnt;
  logic [1:0]     sel;
  logic           valid;
  logic [W-1:0]   o;
  logic [3:0]     hold_cnt;

  modport master (
    output req, d, rdy,
    input  gnt, sel, valid, o, hold_cnt
  );

  modport slave (
    input  req, d, rdy,
    output gnt, sel, valid, o, hold_cnt
  );
endinterface

// File: rtl/rr_mux41_arbiter.sv
// Round-robin 4:1 lane arbiter: 1-cycle req->gnt, grant held for up to MAX_HOLD transfers, stalls while rdy=0.
// Defining RR_MUX41_PRIO0_EN makes lane 0 an urgent lane that wins every arbitration and preempts after one transfer.
module rr_mux41_arbiter #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input logic               clk,
  input logic               rst_n,
  rr_mux41_arbiter_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [3:0] LP_MAX   = 4'(MAX_HOLD);

  logic [0:0] r_state;
  logic [1:0] r_sel;
  logic [1:0] r_last;
  logic [3:0] r_gnt;
  logic [3:0] r_hold;

  logic [0:0]   w_nxt_state;
  logic [1:0]   w_nxt_sel;
  logic [1:0]   w_nxt_last;
  logic [3:0]   w_nxt_hold;
  logic [3:0]   w_sel_oh;
  logic [3:0]   w_others;
  logic         w_other;
  logic         w_xfer;
  logic         w_at_lim;
  logic         w_release;
  logic         w_urgent;
  logic [1:0]   w_rel_last;
  logic [W-1:0] w_lane [4];

  // Search order is last+1 .. last+4 (mod 4), so the previous owner is tried last.
  function automatic logic [1:0] f_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    f_pick = last;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && r[idx]) begin
        f_pick = idx;
        found  = 1'b1;
      end
    end
`ifdef RR_MUX41_PRIO0_EN
    if (r[0]) f_pick = 2'd0;
`endif
  endfunction

  assign w_sel_oh = 4'b0001 << r_sel;
  assign w_others = bus.req & ~w_sel_oh;
  assign w_other  = |w_others;
  assign w_xfer   = (r_state == ST_GRANT) && bus.rdy;
  assign w_at_lim = w_xfer && ((r_hold + 4'd1) == LP_MAX);

`ifdef RR_MUX41_PRIO0_EN
  assign w_urgent   = w_xfer && (r_sel != 2'd0) && bus.req[0];
  assign w_rel_last = (r_sel == 2'd0) ? r_last : r_sel;
`else
  assign w_urgent   = 1'b0;
  assign w_rel_last = r_sel;
`endif

  assign w_release = !bus.req[r_sel] || (w_at_lim && w_other) || w_urgent;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sel   = r_sel;
    w_nxt_last  = r_last;
    w_nxt_hold  = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (|bus.req) begin
          w_nxt_state = ST_GRANT;
          w_nxt_sel   = f_pick(bus.req, r_last);
          w_nxt_hold  = 4'd0;
        end
      end
      default: begin
        if (w_release) begin
          w_nxt_last = w_rel_last;
          w_nxt_hold = 4'd0;
          if (w_other) w_nxt_sel = f_pick(w_others, w_rel_last);
          else         w_nxt_state = ST_IDLE;
        end else if (w_xfer) begin
          // At the limit with nobody else waiting, the owner keeps the lane and the count restarts.
          w_nxt_hold = w_at_lim ? 4'd0 : (r_hold + 4'd1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= 2'd0;
      r_last  <= 2'd3;
      r_gnt   <= 4'd0;
      r_hold  <= 4'd0;
    end else begin
      r_state <= w_nxt_state;
      r_sel   <= w_nxt_sel;
      r_last  <= w_nxt_last;
      r_hold  <= w_nxt_hold;
      r_gnt   <= (w_nxt_state == ST_GRANT) ? (4'b0001 << w_nxt_sel) : 4'b0000;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign w_lane[k] = bus.d[k*W +: W];
  end

  assign bus.gnt      = r_gnt;
  assign bus.sel      = r_sel;
  assign bus.valid    = (r_state == ST_GRANT);
  assign bus.o        = (r_state == ST_GRANT) ? w_lane[r_sel] : '0;
  assign bus.hold_cnt = r_hold;

endmodule

// File: doc/rr_mux41_arbiter.md
Name: rr_mux41_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4:1 data mux. Four requesters compete for one output lane.
- The block registers a 2-bit select that steers the selected requester's data to the output.
- Ownership of the lane is held for a bounded number of accepted transfers.
- Sits between four producer lanes and a single consumer with a valid/ready handshake.

Parameters:
- W, 1, data width per requester lane.
- MAX_HOLD, 4, maximum accepted transfers per grant before a forced hand-off. Legal range is 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per lane, bit k = lane k.
- d  input  4*W  lane data, lane k at d[k*W +: W].
- rdy  input  1  consumer ready.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  registered mux select, encoded index of gnt.
- valid  output  1  output data valid.
- o  output  W  muxed data, o = d[sel*W +: W] while valid=1, else 0.
- hold_cnt  output  4  accepted transfers in the current grant.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; gnt=0, sel=0, valid=0, o=0, hold_cnt=0.
  - last=3, so lane 0 has top priority after reset.
- Reset mid-grant drops gnt/valid immediately, with no waiting for rdy.
- States:
  - IDLE: valid=0.
  - GRANT: valid=1, gnt=onehot(sel).
- Transfer = valid & rdy in a cycle.
- Arbitration order: lanes last+1, last+2, last+3, last (mod 4). The first lane with req=1 wins.
- IDLE -> GRANT:
  - Taken when any req=1; gnt/sel load on that edge (1-cycle req->gnt latency).
  - hold_cnt=0.
- GRANT, release conditions, evaluated each cycle:
  - (a) req[sel]=0.
  - (b) A transfer occurs and hold_cnt+1 == MAX_HOLD, and some other req[j]=1 (j != sel).
- GRANT, on release:
  - last <= sel.
  - If any other lane is requesting, re-arbitrate from the new last and load the next grant on the same edge (no bubble). hold_cnt=0.
  - Otherwise go to IDLE.
- GRANT, no release:
  - A transfer increments hold_cnt.
  - If hold_cnt+1 == MAX_HOLD and no other lane is requesting, keep the grant and clear hold_cnt to 0 (no starvation, no needless bubble).
- Simultaneous events:
  - Transfer in the same cycle as req[sel] falling: the transfer counts, then release via (a).
  - rdy=0 at the hold limit: no transfer, no release; the grant stays until a transfer or req drop.
  - New requests arriving during GRANT never preempt the current grant.
- Invariants:
  - gnt is always zero or one-hot.
  - sel changes only on a grant load.
  - o never shows data of an unselected lane.
  - hold_cnt < MAX_HOLD at all times.

Optional Feature:
- Macro: RR_MUX41_PRIO0_EN
- Defined: lane 0 is an urgent lane.
  - At any arbitration, req[0]=1 wins regardless of last.
  - In GRANT on another lane, req[0]=1 forces a release after the next transfer (before MAX_HOLD), handing to lane 0 on that edge.
  - last is not updated when lane 0 is granted.
- Not defined: pure round-robin as above; lane 0 has no special treatment.

Test Plan:
- Reset, then req=4'b1111, rdy=1, MAX_HOLD=4 -> gnt sequence 0001 x4 transfers, 0010 x4, 0100 x4, 1000 x4, then 0001; no valid=0 bubble between grants.
- req=4'b0100 only, rdy=1 for 10 cycles -> gnt=0100 and sel=2 held continuously; hold_cnt wraps 0,1,2,3,0; valid=1 every cycle after the 1-cycle latency.
- Lane 1 granted, hold_cnt=3, rdy=0 while req=4'b1010 -> gnt stays 0010 and hold_cnt stays 3. Then rdy=1 for one cycle -> next gnt=1000.
- Lane 2 granted, req[2] falls in the same cycle as a transfer with req=4'b0000 -> transfer counted, next cycle IDLE, valid=0, o=0. Later req=4'b0001 -> gnt=0001 (lane 0 after last=2... order 3,0: lane 0 wins).
- Grant active on lane 3, W=1, d=4'b1000: check o=1, then pulse rst_n=0 mid-cycle -> gnt=0, valid=0, o=0 immediately, without waiting for a clock edge.
- With RR_MUX41_PRIO0_EN: lane 2 granted, req=4'b0101, one transfer -> next gnt=0001 with hold_cnt=0. Without the macro the same stimulus gives lane 2 MAX_HOLD transfers first.
